// File: rtl/toggle_gen_if.sv
// Control and status bundle for the toggle generator.
// The controller drives start/stop/configuration; the generator returns the wave and status.
interface toggle_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] half_period;
    logic [CNT_W-1:0] num_toggles;
    logic             a;
    logic             tgl;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, half_period, num_toggles,
        input  a, tgl, busy, done
    );

    modport slave (
        input  start, stop, half_period, num_toggles,
        output a, tgl, busy, done
    );
endinterface

// File: rtl/toggle_gen.sv
// Square-wave generator: toggles output a every half_period clocks for a set
// number of toggles (or forever when num_toggles is 0), with abort and done pulse.
//
// state | meaning
// IDLE  | waiting for start; a holds its last level
// RUN   | counting clocks and toggling a every hp clocks
// DONE  | one-cycle done pulse, then back to IDLE
module toggle_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    toggle_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hp_q, hp_d;
    logic [WIDTH-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] nt_q, nt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             a_q, a_d;
    logic             tgl_q, tgl_d;

    logic [CNT_W-1:0] tcnt_inc;
    logic             toggle_edge;

    assign tcnt_inc    = tcnt_q + CNT_W'(1);
    assign toggle_edge = (cyc_q == hp_q - WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hp_q    <= '0;
            cyc_q   <= '0;
            nt_q    <= '0;
            tcnt_q  <= '0;
            a_q     <= 1'b0;
            tgl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            cyc_q   <= cyc_d;
            nt_q    <= nt_d;
            tcnt_q  <= tcnt_d;
            a_q     <= a_d;
            tgl_q   <= tgl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        cyc_d   = cyc_q;
        nt_d    = nt_q;
        tcnt_d  = tcnt_q;
        a_d     = a_q;
        tgl_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    // A zero half-period would never reach its terminal count.
                    hp_d    = (bus.half_period == '0) ? WIDTH'(1) : bus.half_period;
                    nt_d    = bus.num_toggles;
                    cyc_d   = '0;
                    tcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (toggle_edge) begin
                    a_d    = ~a_q;
                    tgl_d  = 1'b1;
                    cyc_d  = '0;
                    tcnt_d = tcnt_inc;
                    if (nt_q != '0 && tcnt_inc == nt_q) begin
                        state_d = DONE;
                    end
                end else begin
                    cyc_d = cyc_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.a    = a_q;
    assign bus.tgl  = tgl_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_toggle_gen.sv
// Directed bench for toggle_gen: finite run, free-run, stop, async reset,
// ignored changes during a run, and start+stop together in IDLE.
module tb_toggle_gen;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    toggle_gen_if #(.WIDTH(8), .CNT_W(8)) bus ();

    toggle_gen #(.WIDTH(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.half_period = 8'd0;
        bus.num_toggles = 8'd0;
        #3;
        checks++;
        if ({bus.a, bus.tgl, bus.busy, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000", {bus.a, bus.tgl, bus.busy, bus.done});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.a !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d busy %b a %b exp 0 0", i, bus.busy, bus.a);
            end
        end
    endtask

    // hp=3, nt=4 from a=0: a after E1..E12 is 0,0,1,1,1,0,0,0,1,1,1,0
    task automatic test_finite_run();
        logic [12:1] exp_a;
        exp_a = 12'b011100011100;
        bus.half_period = 8'd3;
        bus.num_toggles = 8'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.a !== 1'b0 || bus.tgl !== 1'b0) begin
            errors++;
            $display("FAIL finite_e0 busy %b a %b tgl %b exp 1 0 0", bus.busy, bus.a, bus.tgl);
        end
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (bus.a !== exp_a[e]) begin
                errors++;
                $display("FAIL finite_a E%0d got %b exp %b", e, bus.a, exp_a[e]);
            end
            checks++;
            if (bus.tgl !== (e % 3 == 0)) begin
                errors++;
                $display("FAIL finite_tgl E%0d got %b exp %b", e, bus.tgl, (e % 3 == 0));
            end
            checks++;
            if (bus.busy !== (e < 12) || bus.done !== (e == 12)) begin
                errors++;
                $display("FAIL finite_status E%0d busy %b done %b exp %b %b",
                         e, bus.busy, bus.done, (e < 12), (e == 12));
            end
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tgl !== 1'b0 || bus.a !== 1'b0) begin
            errors++;
            $display("FAIL finite_after done %b busy %b tgl %b a %b exp 0 0 0 0",
                     bus.done, bus.busy, bus.tgl, bus.a);
        end
    endtask

    // hp=0 acts as 1: a toggles every edge; stop on a toggle edge wins.
    task automatic test_free_run_hp0();
        bus.half_period = 8'd0;
        bus.num_toggles = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (bus.a !== logic'(e % 2) || bus.tgl !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL hp0_run E%0d a %b tgl %b busy %b done %b exp %0d 1 1 0",
                         e, bus.a, bus.tgl, bus.busy, bus.done, e % 2);
            end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.a !== 1'b0 || bus.tgl !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL hp0_stop busy %b a %b tgl %b done %b exp 0 0 0 0",
                     bus.busy, bus.a, bus.tgl, bus.done);
        end
    endtask

    task automatic test_stop();
        logic got;
        got = 1'b0;
        bus.half_period = 8'd5;
        bus.num_toggles = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (bus.tgl === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || bus.a !== 1'b1) begin
            errors++;
            $display("FAIL stop_first_toggle seen %b a %b exp 1 1", got, bus.a);
        end
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.a !== 1'b1 || bus.tgl !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL stop_edge busy %b a %b tgl %b done %b exp 0 1 0 0",
                     bus.busy, bus.a, bus.tgl, bus.done);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.a !== 1'b1 || bus.tgl !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL stop_hold cycle %0d busy %b a %b tgl %b done %b exp 0 1 0 0",
                         i, bus.busy, bus.a, bus.tgl, bus.done);
            end
        end
    endtask

    // Run starts from a=1 (left by the stop test); reset lands between edges.
    task automatic test_async_reset();
        bus.half_period = 8'd2;
        bus.num_toggles = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.a !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre a %b busy %b exp 1 1", bus.a, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.a, bus.busy, bus.tgl, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_async a/busy/tgl/done got %b exp 0000",
                     {bus.a, bus.busy, bus.tgl, bus.done});
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.a !== 1'b0 || bus.done !== 1'b0 || bus.tgl !== 1'b0) begin
                errors++;
                $display("FAIL areset_idle cycle %0d busy %b a %b done %b tgl %b exp 0 0 0 0",
                         i, bus.busy, bus.a, bus.done, bus.tgl);
            end
        end
    endtask

    // hp=3, nt=6; half_period set to 7 and start pulsed mid-run.
    task automatic test_ignore_changes();
        int ntog;
        ntog = 0;
        bus.half_period = 8'd3;
        bus.num_toggles = 8'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            bus.half_period = 8'd7;
            bus.num_toggles = 8'd2;
            bus.start = (e == 1);
            if (e % 3 == 0 && e <= 18) ntog++;
            checks++;
            if (bus.tgl !== (e % 3 == 0 && e <= 18) || bus.a !== logic'(ntog % 2)) begin
                errors++;
                $display("FAIL ignore_wave E%0d tgl %b a %b exp %b %0d",
                         e, bus.tgl, bus.a, (e % 3 == 0 && e <= 18), ntog % 2);
            end
            checks++;
            if (bus.busy !== (e < 18) || bus.done !== (e == 18)) begin
                errors++;
                $display("FAIL ignore_status E%0d busy %b done %b exp %b %b",
                         e, bus.busy, bus.done, (e < 18), (e == 18));
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        bus.half_period = 8'd1;
        bus.num_toggles = 8'd0;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.a !== 1'b0 || bus.tgl !== 1'b0) begin
            errors++;
            $display("FAIL start_stop busy %b a %b tgl %b exp 0 0 0", bus.busy, bus.a, bus.tgl);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.a !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_after busy %b a %b exp 0 0", bus.busy, bus.a);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_finite_run();
        test_free_run_hp0();
        test_stop();
        test_async_reset();
        test_ignore_changes();
        test_start_stop_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_gen.md
TOGGLE_GEN -- requirements
Module: toggle_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the half-period counter width.
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the toggle-count width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a run; sampled on the clock edge.
REQ-006 The block SHALL have port stop, input, 1, request to abort a run; sampled on the clock edge.
REQ-007 The block SHALL have port half_period, input, WIDTH, number of clocks between toggles.
REQ-008 The block SHALL have port num_toggles, input, CNT_W, number of toggles in a run, where 0 means free-run.
REQ-009 The block SHALL have port a, output, 1, the square-wave level, driving the inverter input.
REQ-010 The block SHALL have port tgl, output, 1, a one-clock pulse in the cycle after each change of a.
REQ-011 The block SHALL have port busy, output, 1, high while in RUN.
REQ-012 The block SHALL have port done, output, 1, a one-clock pulse on normal run completion.
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 and stop=0, the block SHALL latch half_period and num_toggles, clear the cycle counter and the toggle counter, and enter RUN on the same edge.
REQ-016 A latched half_period of 0 SHALL be treated as 1.
REQ-017 Changes to half_period or num_toggles while in RUN SHALL have no effect.
REQ-018 In RUN, a SHALL invert on every hp-th rising edge after the edge that entered RUN, where hp is the latched half-period, giving a period of 2*hp clocks.
REQ-019 On each toggle edge, the cycle counter SHALL return to 0, the toggle counter SHALL increment, and tgl SHALL be set to 1 for exactly one cycle.
REQ-020 If the latched num_toggles is nonzero, then on the toggle edge where the toggle counter reaches num_toggles, the block SHALL enter DONE.
REQ-021 If the latched num_toggles is 0, the toggle counter SHALL wrap modulo 2^CNT_W and the run SHALL never complete on its own.
REQ-022 In DONE, done=1 and busy=0 for exactly one cycle, after which the block SHALL return to IDLE unconditionally.
REQ-023 stop=1 in RUN SHALL return the block to IDLE on that edge, with a holding its current value, no toggle on that edge, and done staying 0.
REQ-024 If stop and a toggle edge coincide, stop SHALL win.
REQ-025 start in RUN or DONE SHALL be ignored.
REQ-026 start=1 and stop=1 together in IDLE SHALL leave the block in IDLE.
REQ-027 busy SHALL be 1 exactly when the state is RUN.
REQ-028 In IDLE and DONE, a SHALL hold its last value.
REQ-029 A new run SHALL start from the current level of a.

Reset
REQ-030 While rst=1, the block SHALL immediately, without waiting for a clock, force state=IDLE, a=0, tgl=0, busy=0, done=0, and both counters to 0.
REQ-031 Assertion of rst mid-run SHALL abort the run with no done pulse.
REQ-032 After rst is released, the block SHALL remain in IDLE until start is seen.

Verification
REQ-033 The bench SHALL apply half_period=3, num_toggles=4, and a start pulse at edge E0, with a=0 -> a SHALL be 1,0,1,0 after edges E3,E6,E9,E12, tgl SHALL pulse after each of those edges, busy SHALL be 1 from E0 to E12, and done SHALL be 1 for the one cycle after E12.
REQ-034 The bench SHALL apply half_period=0, num_toggles=0, and start -> a SHALL toggle on every edge, busy SHALL stay 1, and done SHALL never assert.
REQ-035 The bench SHALL free-run with half_period=5, then assert stop 2 clocks after a toggle -> busy SHALL be 0 after that edge, a SHALL hold, there SHALL be no further tgl, and done SHALL stay 0.
REQ-036 The bench SHALL assert rst asynchronously mid-run while a=1 -> a, busy, tgl and done SHALL go to 0 before the next edge, and after release the block SHALL stay idle until start.
REQ-037 The bench SHALL pulse start and change half_period 3->7 during RUN -> the toggle spacing SHALL remain 3, and the extra start SHALL be ignored.
REQ-038 The bench SHALL assert start and stop in the same IDLE cycle -> busy SHALL stay 0 and a SHALL stay unchanged.
